// File: rtl/if_fetch.sv
// if_fetch: PC generation, in-order imem req/gnt/rvalid fetch, response FIFO, decode output register.
// FETCH_MISALIGN_CHECK_EN adds fetch_misalign_o and halts fetch after a misaligned redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fetch_misalign_o,
`endif
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(BUF_DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic          vld_q, vld_d;
  logic [31:0]   fpc_q [BUF_DEPTH];
  logic [31:0]   fin_q [BUF_DEPTH];

  logic          halt;
  logic [CW:0]   credit;
  logic          grant, accept, push, pop, bypass;
  logic [31:0]   target;
  logic          unused_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign halt             = misalign_q;
  assign fetch_misalign_o = misalign_q;
  always_comb begin
    misalign_d = misalign_q;
    if (branch_flag_i) misalign_d = |branch_target_i[1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign halt = 1'b0;
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign unused_tgt  = ^branch_target_i[1:0];
  assign target      = {branch_target_i[31:2], 2'b00};
  assign credit      = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_o  = !rst && !branch_flag_i && !halt
                       && (credit < DEPTH_W);
  assign imem_addr_o = fetch_pc_q;

  assign grant  = imem_req_o && imem_gnt_i;
  assign accept = imem_rvalid_i && (drop_q == '0) && !branch_flag_i;
  assign pop    = !stall_i && !branch_flag_i && (cnt_q != '0);
  assign push   = accept && (stall_i || (cnt_q != '0));
  assign bypass = accept && !stall_i && (cnt_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    vld_d      = vld_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    unique case ({grant, imem_rvalid_i})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (accept) resp_pc_d = resp_pc_q + 32'd4;
    if (push) wr_d = nxt(wr_q);
    if (pop)  rd_d = nxt(rd_q);
    if (pop) begin
      pc_d   = fpc_q[rd_q];
      inst_d = fin_q[rd_q];
      vld_d  = 1'b1;
    end else if (bypass) begin
      pc_d   = resp_pc_q;
      inst_d = imem_rdata_i;
      vld_d  = 1'b1;
    end else if (!stall_i) begin
      inst_d = '0;
      vld_d  = 1'b0;
    end
    // Redirect wins over stall; everything in flight becomes drop credit.
    if (branch_flag_i) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      drop_d     = out_q - CW'(imem_rvalid_i);
      inst_d     = '0;
      vld_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      vld_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      vld_q      <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fpc_q[wr_q] <= resp_pc_q;
      fin_q[wr_q] <= imem_rdata_i;
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = vld_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an in-order variable-latency imem model.
// Memory word at address a is ~a.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign_o;
`endif

  if_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign_o(fetch_misalign_o),
`endif
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic [31:0] q_addr[$];
  int          q_due[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic prep();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = ~q_addr[0];
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    imem_gnt_i = gnt_en;
    #1;
  endtask

  task automatic fin();
    if (!rst && imem_req_o && imem_gnt_i) begin
      q_addr.push_back(imem_addr_o);
      q_due.push_back(cyc + lat);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    prep();
    fin();
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (inst_valid_o) found = 1'b1;
    end
    chk({tag, "_seen"}, {31'b0, found}, 32'd1);
    chk({tag, "_pc"}, pc_o, exp_pc);
    chk({tag, "_inst"}, inst_o, ~exp_pc);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n;
    logic [3:0]  gpat;
    rst = 1'b1;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_i = '0;
    imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    @(negedge clk);

    // reset state
    step();
    prep();
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    fin();
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    rst = 1'b0;

    // sequential fetch, latency 1
    prep();
    chk("seq_req0", {31'b0, imem_req_o}, 32'd1);
    chk("seq_addr0", imem_addr_o, 32'h0);
    fin();
    chk("seq_v0", {31'b0, inst_valid_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      prep();
      chk("seq_addr", imem_addr_o, 32'(4 * (i + 1)));
      fin();
      chk("seq_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("seq_pc", pc_o, 32'(4 * i));
      chk("seq_inst", inst_o, ~32'(4 * i));
    end

    // stall five cycles
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prep();
      if (i > 0) chk("stall_noreq", {31'b0, imem_req_o}, 32'd0);
      fin();
      chk("stall_pc", pc_o, 32'h8);
      chk("stall_valid", {31'b0, inst_valid_o}, 32'd1);
    end
    stall_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rel_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("rel_pc", pc_o, 32'(12 + 4 * i));
      chk("rel_inst", inst_o, ~32'(12 + 4 * i));
    end

    // branch with two outstanding, latency 3
    rst = 1'b1;
    step();
    rst = 1'b0;
    lat = 3;
    step();
    step();
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    prep();
    chk("br_noreq", {31'b0, imem_req_o}, 32'd0);
    fin();
    chk("br_bubble", {31'b0, inst_valid_o}, 32'd0);
    branch_flag_i = 1'b0;
    step();
    prep();
    chk("br_req", {31'b0, imem_req_o}, 32'd1);
    chk("br_addr", imem_addr_o, 32'h100);
    fin();
    wait_valid("br_first", 32'h100);

    // branch and stall together
    branch_flag_i = 1'b1;
    stall_i = 1'b1;
    branch_target_i = 32'h200;
    prep();
    chk("bs_noreq", {31'b0, imem_req_o}, 32'd0);
    fin();
    chk("bs_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("bs_inst", inst_o, 32'h0);
    chk("bs_pc", pc_o, 32'h100);
    branch_flag_i = 1'b0;
    stall_i = 1'b0;
    prep();
    chk("bs_req", {31'b0, imem_req_o}, 32'd1);
    chk("bs_addr", imem_addr_o, 32'h200);
    fin();
    wait_valid("bs_first", 32'h200);

    // grant pattern 1,0,0,1 with latency 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    lat = 1;
    gpat = 4'b1001;
    exp_pc = 32'h0;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      gnt_en = gpat[3 - (i % 4)];
      prep();
      chk("gt_outst", {31'b0, q_addr.size() <= 2}, 32'd1);
      fin();
      if (inst_valid_o) begin
        chk("gt_pc", pc_o, exp_pc);
        chk("gt_inst", inst_o, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
    end
    chk("gt_count", {31'b0, n >= 8}, 32'd1);

    // reset with FIFO full
    gnt_en = 1'b1;
    step();
    step();
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    prep();
    chk("full_noreq", {31'b0, imem_req_o}, 32'd0);
    fin();
    rst = 1'b1;
    prep();
    chk("mrst_req", {31'b0, imem_req_o}, 32'd0);
    fin();
    chk("mrst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("mrst_pc", pc_o, 32'h0);
    chk("mrst_inst", inst_o, 32'h0);
    rst = 1'b0;
    stall_i = 1'b0;
    prep();
    chk("mrst_req1", {31'b0, imem_req_o}, 32'd1);
    chk("mrst_addr", imem_addr_o, 32'h0);
    fin();
    wait_valid("mrst_first", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
